// File: rtl/pkt_tx_pkg.sv
// pkt_bus_tx shared types and constants.
// Header checksum helpers are used only with PKT_TX_IPV4_CSUM_EN.
package pkt_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIX,
    SEND
  } state_t;

  localparam int          ETH_HDR_B     = 14;
  localparam logic [15:0] ETYPE_IPV4    = 16'h0800;
  localparam int          IPV4_CSUM_OFS = 24;

  function automatic logic [15:0] csum_fold(
    input logic [31:0] a
  );
    logic [16:0] s1;
    logic [16:0] s2;
    s1 = {1'b0, a[15:0]} + {1'b0, a[31:16]};
    s2 = {1'b0, s1[15:0]} + {16'b0, s1[16]};
    return s2[15:0];
  endfunction

endpackage

// File: rtl/pkt_tx_csum_acc.sv
// Running ones-complement sum over the IPv4 header window.
// Tracks EtherType and IHL as bytes stream in.
module pkt_tx_csum_acc
  import pkt_tx_pkg::*;
#(
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [LEN_W-1:0] idx,
  input  logic [7:0]       data,
  input  logic [LEN_W-1:0] len,
  output logic             ok,
  output logic [15:0]      csum
);

  logic [7:0]       et_hi;
  logic             et_ok;
  logic [3:0]       ihl;
  logic [7:0]       hi;
  logic [31:0]      acc;
  logic [3:0]       ihl_cur;
  logic [LEN_W-1:0] hdr_end;
  logic [LEN_W-1:0] ofs_eth;
  logic [LEN_W-1:0] ofs_ck;
  logic             in_win;

  // Window bounds; IHL is live on the byte that carries it
  always_comb begin
    ofs_eth = LEN_W'(ETH_HDR_B);
    ofs_ck  = LEN_W'(IPV4_CSUM_OFS);
    ihl_cur = (idx == ofs_eth) ? data[3:0] : ihl;
    hdr_end = ofs_eth + LEN_W'({ihl_cur, 2'b00});
    in_win  = (idx >= ofs_eth) && (idx < hdr_end);
    ok      = et_ok && (ihl >= 4'd5) &&
              (len >= ofs_eth + LEN_W'({ihl, 2'b00}));
    csum    = ~csum_fold(acc);
  end

  // Capture EtherType/IHL and sum 16-bit words, skipping the csum field
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      et_hi <= '0;
      et_ok <= 1'b0;
      ihl   <= '0;
      hi    <= '0;
      acc   <= '0;
    end else if (clr) begin
      et_hi <= '0;
      et_ok <= 1'b0;
      ihl   <= '0;
      hi    <= '0;
      acc   <= '0;
    end else if (we) begin
      if (idx == LEN_W'(ETH_HDR_B - 2))
        et_hi <= data;
      if (idx == LEN_W'(ETH_HDR_B - 1))
        et_ok <= ({et_hi, data} == ETYPE_IPV4);
      if (idx == ofs_eth)
        ihl <= data[3:0];
      if (in_win) begin
        if (!idx[0])
          hi <= data;
        else if (idx != ofs_ck + LEN_W'(1))
          acc <= acc + {16'b0, hi, data};
      end
    end
  end

endmodule

// File: rtl/pkt_bus_tx.sv
// Store-and-forward byte stream to left-aligned bus beats.
// Optional IPv4 checksum insertion: PKT_TX_IPV4_CSUM_EN.
module pkt_bus_tx
  import pkt_tx_pkg::*;
#(
  parameter int BUS_WIDTH_B = 16,
  parameter int MAX_PKT_B   = 1024,
  parameter int LEN_W       = $clog2(MAX_PKT_B + 1)
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [7:0]                 wr_data,
  input  logic                       wr_last,
  input  logic                       out_ready,
  output logic [BUS_WIDTH_B*8-1:0]   bus,
  output logic                       bus_valid,
  output logic                       start_of_packet_o,
  output logic                       end_of_packet_o,
  output logic [$clog2(BUS_WIDTH_B):0] last_bytes_o,
  output logic                       ovf_o
);

  localparam int AW = $clog2(MAX_PKT_B);
  localparam int BW = $clog2(BUS_WIDTH_B);

  state_t           state;
  state_t           nxt;
  state_t           post;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] beat;
  logic             live;
  logic [7:0]       mem [MAX_PKT_B];
  logic             take;
  logic             full;
  logic [LEN_W:0]   nbeats;
  logic [LEN_W:0]   rem;
  logic [LEN_W:0]   idx;
  logic             is_last;
  logic             beat_acc;
  logic             done;

`ifdef PKT_TX_IPV4_CSUM_EN
  logic             ck_ok;
  logic [15:0]      ck_val;

  pkt_tx_csum_acc #(
    .LEN_W (LEN_W)
  ) u_csum (
    .clk   (CLK),
    .rst_n (reset),
    .clr   (done),
    .we    (take && !full),
    .idx   (len),
    .data  (wr_data),
    .len   (len),
    .ok    (ck_ok),
    .csum  (ck_val)
  );
  assign post = FIX;
`else
  assign post = SEND;
`endif

  // Handshake and beat bookkeeping
  always_comb begin
    take     = wr_valid && wr_ready;
    full     = (len == LEN_W'(MAX_PKT_B));
    nbeats   = ({1'b0, len} + (LEN_W+1)'(BUS_WIDTH_B - 1)) >> BW;
    rem      = {1'b0, len} - ((nbeats - 1'b1) << BW);
    is_last  = ({1'b0, beat} == nbeats - 1'b1);
    wr_ready = live && (state == IDLE || state == LOAD);
    bus_valid         = (state == SEND);
    start_of_packet_o = bus_valid && (beat == '0);
    end_of_packet_o   = bus_valid && is_last;
    beat_acc = bus_valid && out_ready;
    done     = beat_acc && is_last;
    ovf_o    = take && wr_last && full;
    last_bytes_o = end_of_packet_o ? rem[BW:0] : '0;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (take) nxt = wr_last ? post : LOAD;
      LOAD: if (take && wr_last) nxt = post;
      FIX:  nxt = SEND;
      SEND: if (done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State, length, beat counters
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      len   <= '0;
      beat  <= '0;
      live  <= 1'b0;
    end else begin
      state <= nxt;
      live  <= 1'b1;
      if (done)
        len <= '0;
      else if (take && !full)
        len <= len + 1'b1;
      if (done)
        beat <= '0;
      else if (beat_acc)
        beat <= beat + 1'b1;
    end
  end

  // Packet buffer; contents need no reset
  always_ff @(posedge CLK) begin
    if (take && !full)
      mem[len[AW-1:0]] <= wr_data;
`ifdef PKT_TX_IPV4_CSUM_EN
    else if (state == FIX && ck_ok) begin
      mem[IPV4_CSUM_OFS]     <= ck_val[15:8];
      mem[IPV4_CSUM_OFS + 1] <= ck_val[7:0];
    end
`endif
  end

  // Beat assembly; lanes past len read as zero
  always_comb begin
    bus = '0;
    idx = '0;
    if (state == SEND) begin
      for (int k = 0; k < BUS_WIDTH_B; k++) begin
        idx = ({1'b0, beat} << BW) + (LEN_W+1)'(k);
        if (idx < {1'b0, len})
          bus[(BUS_WIDTH_B-k)*8-1 -: 8] = mem[idx[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_pkt_bus_tx.sv
// Directed bench for pkt_bus_tx: packet vectors plus reset,
// overflow, backpressure and optional checksum sequences.
module tb_pkt_bus_tx;

  localparam int B   = 16;
  localparam int MAX = 1024;

  logic         CLK = 1'b0;
  logic         reset = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [7:0]   wr_data = 8'h00;
  logic         wr_last = 1'b0;
  logic         out_ready = 1'b0;
  logic [B*8-1:0] bus;
  logic         bus_valid;
  logic         start_of_packet_o;
  logic         end_of_packet_o;
  logic [4:0]   last_bytes_o;
  logic         ovf_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] pkt [0:1099];

  typedef struct {
    int len;
    bit toggle;
    int beats;
    int lastb;
    bit ovf;
  } vec_t;

  vec_t vt [8];

  pkt_bus_tx #(
    .BUS_WIDTH_B (B),
    .MAX_PKT_B   (MAX)
  ) dut (
    .CLK               (CLK),
    .reset             (reset),
    .wr_valid          (wr_valid),
    .wr_ready          (wr_ready),
    .wr_data           (wr_data),
    .wr_last           (wr_last),
    .out_ready         (out_ready),
    .bus               (bus),
    .bus_valid         (bus_valid),
    .start_of_packet_o (start_of_packet_o),
    .end_of_packet_o   (end_of_packet_o),
    .last_bytes_o      (last_bytes_o),
    .ovf_o             (ovf_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fill(input int seed);
    for (int i = 0; i < 1100; i++)
      pkt[i] = 8'(i * 13 + seed);
  endtask

  function automatic logic [127:0] exp_beat(input int len,
                                            input int bi);
    logic [127:0] w;
    int eff;
    int ix;
    w = '0;
    eff = (len > MAX) ? MAX : len;
    for (int k = 0; k < B; k++) begin
      ix = bi * B + k;
      if (ix < eff)
        w[(B-k)*8-1 -: 8] = pkt[ix];
    end
    return w;
  endfunction

  task automatic send(input int len, input bit exp_ovf);
    int n;
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      wr_valid = 1'b1;
      wr_data  = pkt[i];
      wr_last  = (i == len - 1);
      #1;
      n = 0;
      while (!wr_ready && n < 50) begin
        @(negedge CLK);
        #1;
        n++;
      end
      if (!wr_ready) begin
        chk("wr_ready_timeout", 128'(wr_ready), 128'(1));
        break;
      end
      if (i == len - 1)
        chk("ovf_at_last", 128'(ovf_o), 128'(exp_ovf));
    end
    @(negedge CLK);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic recv(input int len, input bit toggle,
                      input int nb, input int lastb);
    int bi;
    int cyc;
    bit first;
    bi = 0;
    cyc = 0;
    first = 1'b1;
    while (bi < nb && cyc < 1000) begin
      out_ready = toggle ? cyc[0] : 1'b1;
      #1;
      if (first) begin
`ifdef PKT_TX_IPV4_CSUM_EN
        chk("latency", 128'(bus_valid), 128'(0));
`else
        chk("latency", 128'(bus_valid), 128'(1));
`endif
        first = 1'b0;
      end
      if (bus_valid) begin
        chk("bus", bus, exp_beat(len, bi));
        chk("sop", 128'(start_of_packet_o), 128'(bi == 0));
        chk("eop", 128'(end_of_packet_o), 128'(bi == nb - 1));
        chk("last_bytes", 128'(last_bytes_o),
            128'((bi == nb - 1) ? lastb : 0));
        if (out_ready)
          bi++;
      end
      cyc++;
      @(negedge CLK);
    end
    if (bi < nb)
      chk("beat_timeout", 128'(bi), 128'(nb));
    out_ready = 1'b1;
    #1;
    chk("idle_valid", 128'(bus_valid), 128'(0));
    chk("idle_ready", 128'(wr_ready), 128'(1));
  endtask

  initial begin
    vt[0] = '{len: 60,   toggle: 0, beats: 4,  lastb: 12, ovf: 0};
    vt[1] = '{len: 32,   toggle: 0, beats: 2,  lastb: 16, ovf: 0};
    vt[2] = '{len: 5,    toggle: 0, beats: 1,  lastb: 5,  ovf: 0};
    vt[3] = '{len: 48,   toggle: 1, beats: 3,  lastb: 16, ovf: 0};
    vt[4] = '{len: 1,    toggle: 0, beats: 1,  lastb: 1,  ovf: 0};
    vt[5] = '{len: 17,   toggle: 1, beats: 2,  lastb: 1,  ovf: 0};
    vt[6] = '{len: 1024, toggle: 0, beats: 64, lastb: 16, ovf: 0};
    vt[7] = '{len: 1030, toggle: 0, beats: 64, lastb: 16, ovf: 1};

    #12;
    chk("rst_valid", 128'(bus_valid), 128'(0));
    chk("rst_bus", bus, 128'(0));
    chk("rst_ready", 128'(wr_ready), 128'(0));
    chk("rst_ovf", 128'(ovf_o), 128'(0));
    @(negedge CLK);
    reset = 1'b1;

    for (int v = 0; v < 8; v++) begin
      fill(v + 5);
      send(vt[v].len, vt[v].ovf);
      recv(vt[v].len, vt[v].toggle, vt[v].beats, vt[v].lastb);
    end

`ifdef PKT_TX_IPV4_CSUM_EN
    begin
      logic [7:0] hdr [20];
      hdr = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00,
              8'h40, 8'h00, 8'h40, 8'h11, 8'h00, 8'h00,
              8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8,
              8'h00, 8'hc7};
      fill(1);
      pkt[12] = 8'h08;
      pkt[13] = 8'h00;
      for (int i = 0; i < 20; i++)
        pkt[14 + i] = hdr[i];
      send(60, 1'b0);
      pkt[24] = 8'hb8;
      pkt[25] = 8'h61;
      recv(60, 1'b0, 4, 12);
      fill(1);
      pkt[12] = 8'h86;
      pkt[13] = 8'hdd;
      for (int i = 0; i < 20; i++)
        pkt[14 + i] = hdr[i];
      send(60, 1'b0);
      recv(60, 1'b0, 4, 12);
    end
`endif

    fill(9);
    send(64, 1'b0);
    out_ready = 1'b1;
`ifdef PKT_TX_IPV4_CSUM_EN
    @(negedge CLK);
`endif
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("pre_rst_bus", bus, exp_beat(64, 2));
    chk("pre_rst_eop", 128'(end_of_packet_o), 128'(0));
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(bus_valid), 128'(0));
    chk("mid_rst_bus", bus, 128'(0));
    chk("mid_rst_sop", 128'(start_of_packet_o), 128'(0));
    chk("mid_rst_eop", 128'(end_of_packet_o), 128'(0));
    chk("mid_rst_ready", 128'(wr_ready), 128'(0));
    @(negedge CLK);
    reset = 1'b1;
    fill(3);
    send(5, 1'b0);
    recv(5, 1'b0, 1, 5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
